// File: rtl/chess_pkg.sv
// chess_pkg: shared board geometry, direction/piece/colour codes and ray steps for the move engine
package chess_pkg;
  localparam int BOARD_DIM = 8;
  localparam int SQ_W = 6;
  localparam int COORD_W = SQ_W / 2;
  localparam logic [COORD_W-1:0] EDGE_HI = COORD_W'(BOARD_DIM - 1);
  typedef enum logic [1:0] {UP = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, DOWN = 2'b11} dir_t;
  typedef enum logic [2:0] {EMPTY = 3'd0, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING} piece_t;
  typedef enum logic {WHITE = 1'b0, BLACK = 1'b1} color_t;
  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, MARK, NEXT, DONE} state_t;
  localparam logic [SQ_W-1:0] STEP_UP = SQ_W'(BOARD_DIM);
  localparam logic [SQ_W-1:0] STEP_DOWN = SQ_W'(-BOARD_DIM);
  localparam logic [SQ_W-1:0] STEP_RIGHT = SQ_W'(1);
  localparam logic [SQ_W-1:0] STEP_LEFT = SQ_W'(-1);
endpackage

// File: rtl/ray_step.sv
// ray_step: next square along a straight ray and whether the square already sits on that ray's board edge
module ray_step
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0] sq,
  input  dir_t            dir,
  output logic [SQ_W-1:0] next_sq,
  output logic            at_edge
);
  logic [COORD_W-1:0] row, col;
  // split the square into row/col, pick the edge test and step for the direction
  always_comb begin
    row = sq[SQ_W-1:COORD_W];
    col = sq[COORD_W-1:0];
    at_edge = dir == UP ? row == EDGE_HI :
              dir == DOWN ? row == '0 :
              dir == RIGHT ? col == EDGE_HI : col == '0;
    next_sq = sq + (dir == UP ? STEP_UP :
                    dir == DOWN ? STEP_DOWN :
                    dir == RIGHT ? STEP_RIGHT : STEP_LEFT);
  end
endmodule

// File: rtl/straight_move_gen.sv
// straight_move_gen: rook/queen straight-line target mask builder driving the ray scanner (CAPTURE_MASK_EN adds capture_mask)
module straight_move_gen
  import chess_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SQ_W-1:0] start_pos,
  input  logic            mover_color,
  output logic            busy,
  output logic            done,
`ifdef CAPTURE_MASK_EN
  output logic [63:0]     capture_mask,
`endif
  output logic [63:0]     move_mask,
  output logic            scan_req,
  output logic [SQ_W-1:0] scan_pos,
  output logic [1:0]      scan_dir,
  input  logic            scan_valid,
  input  logic [SQ_W-1:0] nearest_pos,
  input  logic [2:0]      nearest_piece,
  input  logic            nearest_color
);
  state_t          state;
  dir_t            dir;
  logic [SQ_W-1:0] origin, cursor, near_pos, rs_sq, next_sq;
  logic [2:0]      near_piece;
  logic            color, near_color, at_edge;
  // the origin is stepped while checking/waiting, the cursor while walking the ray
  assign rs_sq = state == MARK ? cursor : origin;
  ray_step u_step (.sq(rs_sq), .dir(dir), .next_sq(next_sq), .at_edge(at_edge));
  // sequencer: per direction check edge, request a scan, wait for the result, walk the ray
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      scan_req <= 1'b0;
      move_mask <= '0;
`ifdef CAPTURE_MASK_EN
      capture_mask <= '0;
`endif
      scan_pos <= '0;
      scan_dir <= '0;
      origin <= '0;
      color <= 1'b0;
      dir <= UP;
      cursor <= '0;
      near_pos <= '0;
      near_piece <= EMPTY;
      near_color <= 1'b0;
    end else begin
      done <= 1'b0;
      scan_req <= 1'b0;
      case (state)
        IDLE: if (start) begin
          origin <= start_pos;
          color <= mover_color;
          move_mask <= '0;
`ifdef CAPTURE_MASK_EN
          capture_mask <= '0;
`endif
          dir <= UP;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (at_edge) state <= NEXT;
        else begin
          scan_req <= 1'b1;
          scan_pos <= origin;
          scan_dir <= dir;
          state <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (scan_valid) begin
          near_pos <= nearest_pos;
          near_piece <= nearest_piece;
          near_color <= nearest_color;
          cursor <= next_sq;
          state <= MARK;
        end
        MARK: if (cursor == near_pos) begin
          if (near_piece == EMPTY || near_color != color) move_mask[cursor] <= 1'b1;
`ifdef CAPTURE_MASK_EN
          if (near_piece != EMPTY && near_color != color) capture_mask[cursor] <= 1'b1;
`endif
          state <= NEXT;
        end else begin
          move_mask[cursor] <= 1'b1;
          if (at_edge) state <= NEXT;
          else cursor <= next_sq;
        end
        NEXT: if (dir == DOWN) begin
          done <= 1'b1;
          state <= DONE;
        end else begin
          dir <= dir_t'(dir + 2'd1);
          state <= CHECK;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
